// File: rtl/analyzer_pkg.sv
// Shared definitions for the analyzer capture controller: state codes and default sizes.
package analyzer_pkg;

   localparam int unsigned DEFAULT_DATA_W  = 32;
   localparam int unsigned DEFAULT_DEPTH_W = 13;

   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      WAIT_TRIG,
      POST,
      DRAIN,
      FLUSH
   } state_t;

endpackage

// File: rtl/analyzer_rd_stage.sv
// Two-entry skid buffer that absorbs the one-cycle FIFO read latency on the readout path.
module analyzer_rd_stage
   import analyzer_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              issue,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              can_issue
);

   logic [1:0]        held;
   logic              inflight;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;

   // The word leaving this cycle frees a slot, which keeps a 1 word/cycle stream.
   always_comb begin
      valid     = (held != 2'd0);
      data      = head;
      can_issue = ((held + {1'b0, inflight}) < 2'd2) || pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held     <= '0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
      end else if (clear) begin
         held     <= '0;
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= issue;
         case ({inflight, pop})
            2'b10: begin
               if (held == 2'd0) head <= rd_data;
               else              tail <= rd_data;
               held <= held + 2'd1;
            end
            2'b01: begin
               head <= tail;
               held <= held - 2'd1;
            end
            2'b11: begin
               if (held == 2'd1) begin
                  head <= rd_data;
               end else begin
                  head <= tail;
                  tail <= rd_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/analyzer_capture_ctrl.sv
// Triggered-capture sequencer for one analyzer sample FIFO: arm, pre-trigger ring fill,
// trigger, post-trigger fill, then drain to a valid/ready readout stream.
module analyzer_capture_ctrl
   import analyzer_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned DEPTH_W = DEFAULT_DEPTH_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               abort,
   input  logic               force_trig,
   input  logic [DEPTH_W-1:0] pre_len,
   input  logic [DEPTH_W:0]   post_len,
   input  logic [DATA_W-1:0]  trig_mask,
   input  logic [DATA_W-1:0]  trig_value,
   input  logic [DATA_W-1:0]  sample_in,
   input  logic               sample_en,
   output logic               fifo_wr_en,
   output logic [DATA_W-1:0]  fifo_wr_data,
   input  logic               fifo_wr_full,
   output logic               fifo_rd_en,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   input  logic               fifo_rd_empty,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               triggered,
   output logic [DEPTH_W-1:0] trig_index,
   output logic               overflow,
   output logic               done
);

   localparam int unsigned CW = DEPTH_W + 1;

   state_t             state, state_nx;
   logic [DEPTH_W-1:0] pre_q, pre_nx, occ, occ_nx, occ_inc, trig_index_nx;
   logic [CW-1:0]      post_eff_q, post_eff_nx, post_cnt, post_cnt_nx;
   logic [CW-1:0]      rd_left, rd_left_nx, out_left, out_left_nx;
   logic [CW-1:0]      room, post_clamp, post_eff_arm;
   logic [DATA_W-1:0]  mask_q, mask_nx, value_q, value_nx;
   logic               triggered_nx, overflow_nx, done_nx;
   logic               hit, want_wr, rd_issue, rd_discard, trig_now, enter_drain;
   logic               stage_valid, can_issue, pop;

   always_comb begin
      room         = {1'b1, {DEPTH_W{1'b0}}} - {1'b0, pre_len};
      post_clamp   = (post_len < room) ? post_len : room;
      post_eff_arm = (post_clamp == '0) ? CW'(1) : post_clamp;
      hit          = sample_en && ((sample_in & mask_q) == (value_q & mask_q));
      occ_inc      = occ + DEPTH_W'(1);
      out_valid    = stage_valid && (state == DRAIN);
      pop          = out_valid && out_ready;
      out_last     = out_valid && (out_left == CW'(1));
      busy         = (state != IDLE);
      fifo_wr_data = sample_in;
   end

   always_comb begin
      state_nx      = state;
      pre_nx        = pre_q;
      post_eff_nx   = post_eff_q;
      mask_nx       = mask_q;
      value_nx      = value_q;
      occ_nx        = occ;
      post_cnt_nx   = post_cnt;
      rd_left_nx    = rd_left;
      out_left_nx   = out_left;
      trig_index_nx = trig_index;
      triggered_nx  = triggered;
      overflow_nx   = overflow;
      done_nx       = 1'b0;
      want_wr       = 1'b0;
      rd_issue      = 1'b0;
      rd_discard    = 1'b0;
      trig_now      = 1'b0;
      enter_drain   = 1'b0;

      case (state)
         IDLE: begin
            if (arm) begin
               pre_nx        = pre_len;
               post_eff_nx   = post_eff_arm;
               mask_nx       = trig_mask;
               value_nx      = trig_value;
               occ_nx        = '0;
               post_cnt_nx   = '0;
               trig_index_nx = '0;
               triggered_nx  = 1'b0;
               overflow_nx   = 1'b0;
               state_nx      = (pre_len != '0) ? PREFILL : WAIT_TRIG;
            end
         end
         PREFILL: begin
            if (abort) begin
               state_nx = FLUSH;
            end else if (force_trig) begin
               trig_now = 1'b1;
            end else if (sample_en) begin
               want_wr = 1'b1;
               occ_nx  = occ_inc;
               if (occ_inc == pre_q) state_nx = WAIT_TRIG;
            end
         end
         WAIT_TRIG: begin
            if (abort) begin
               state_nx = FLUSH;
            end else if (hit || force_trig) begin
               trig_now = 1'b1;
            end else if (sample_en && (pre_q != '0)) begin
               // Ring behaviour: drop the oldest word as the newest one goes in.
               want_wr    = 1'b1;
               rd_discard = 1'b1;
            end
         end
         POST: begin
            if (abort) begin
               state_nx = FLUSH;
            end else if (post_cnt >= post_eff_q) begin
               enter_drain = 1'b1;
            end else if (sample_en) begin
               want_wr     = 1'b1;
               post_cnt_nx = post_cnt + CW'(1);
               if (post_cnt_nx == post_eff_q) enter_drain = 1'b1;
            end
         end
         DRAIN: begin
            if (abort) begin
               state_nx = FLUSH;
            end else begin
               rd_issue = !fifo_rd_empty && can_issue && (rd_left != '0);
               if (rd_issue) rd_left_nx = rd_left - CW'(1);
               if (pop) begin
                  out_left_nx = out_left - CW'(1);
                  if (out_left == CW'(1)) begin
                     state_nx = IDLE;
                     done_nx  = 1'b1;
                  end
               end
            end
         end
         FLUSH: begin
            if (fifo_rd_empty) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (trig_now) begin
         want_wr       = sample_en;
         trig_index_nx = occ;
         post_cnt_nx   = sample_en ? CW'(1) : '0;
         triggered_nx  = 1'b1;
         state_nx      = POST;
      end
      if (enter_drain) begin
         state_nx    = DRAIN;
         rd_left_nx  = {1'b0, trig_index} + post_eff_q;
         out_left_nx = {1'b0, trig_index} + post_eff_q;
      end
      if (want_wr && fifo_wr_full) overflow_nx = 1'b1;

      fifo_wr_en = want_wr && !fifo_wr_full;
      fifo_rd_en = rd_issue || rd_discard || ((state == FLUSH) && !fifo_rd_empty);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pre_q      <= '0;
         post_eff_q <= '0;
         mask_q     <= '0;
         value_q    <= '0;
         occ        <= '0;
         post_cnt   <= '0;
         rd_left    <= '0;
         out_left   <= '0;
         trig_index <= '0;
         triggered  <= 1'b0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         pre_q      <= pre_nx;
         post_eff_q <= post_eff_nx;
         mask_q     <= mask_nx;
         value_q    <= value_nx;
         occ        <= occ_nx;
         post_cnt   <= post_cnt_nx;
         rd_left    <= rd_left_nx;
         out_left   <= out_left_nx;
         trig_index <= trig_index_nx;
         triggered  <= triggered_nx;
         overflow   <= overflow_nx;
         done       <= done_nx;
      end
   end

   analyzer_rd_stage #(
      .DATA_W (DATA_W)
   ) u_rd_stage (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == FLUSH),
      .issue     (rd_issue),
      .rd_data   (fifo_rd_data),
      .pop       (pop),
      .valid     (stage_valid),
      .data      (out_data),
      .can_issue (can_issue)
   );

endmodule
